// File: rtl/simd_pkg.sv
// Shared op codes and sequencer state encoding for the SIMD lane sequencer.
package simd_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_INC = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/simd_lane_sequencer.sv
// Serialises one vector op lane by lane through the shared scalar ALU
// and gathers the per-lane results and flags into a result vector.
module simd_lane_sequencer
    import simd_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int LANES     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [LANES*DATA_SIZE-1:0] in_vec_a,
    input  logic [LANES*DATA_SIZE-1:0] in_vec_b,
    output logic [2:0]                 alu_op_select,
    output logic [DATA_SIZE-1:0]       alu_operand1,
    output logic [DATA_SIZE-1:0]       alu_operand2,
    input  logic [DATA_SIZE-1:0]       alu_result,
    input  logic                       alu_neg_flag,
    input  logic                       alu_zero_flag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*DATA_SIZE-1:0] out_vec,
    output logic [LANES-1:0]           out_neg_mask,
    output logic [LANES-1:0]           out_zero_mask,
    output logic                       busy
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    seq_state_t state;
    seq_state_t state_next;

    logic [LANE_W-1:0]          lane_idx;
    logic [2:0]                 op_q;
    logic [LANES*DATA_SIZE-1:0] vec_a_q;
    logic [LANES*DATA_SIZE-1:0] vec_b_q;

    logic accept;
    logic release_out;

    assign in_ready    = (state == S_IDLE) && !rst;
    assign out_valid   = (state == S_DONE);
    assign busy        = (state == S_ISSUE) || (state == S_DONE);
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lane_idx == LAST_LANE) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (release_out) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The ALU is driven with zeros whenever no lane is in flight.
    always_comb begin
        alu_op_select = OP_NOP;
        alu_operand1  = '0;
        alu_operand2  = '0;
        if (state == S_ISSUE) begin
            alu_op_select = op_q;
            alu_operand1  = vec_a_q[lane_idx*DATA_SIZE +: DATA_SIZE];
            alu_operand2  = vec_b_q[lane_idx*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_idx      <= '0;
            op_q          <= OP_NOP;
            vec_a_q       <= '0;
            vec_b_q       <= '0;
            out_vec       <= '0;
            out_neg_mask  <= '0;
            out_zero_mask <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q          <= in_op;
                        vec_a_q       <= in_vec_a;
                        vec_b_q       <= in_vec_b;
                        lane_idx      <= '0;
                        out_neg_mask  <= '0;
                        out_zero_mask <= '0;
                    end
                end
                S_ISSUE: begin
                    out_vec[lane_idx*DATA_SIZE +: DATA_SIZE] <= alu_result;
                    out_neg_mask[lane_idx]  <= alu_neg_flag;
                    out_zero_mask[lane_idx] <= alu_zero_flag;
                    if (lane_idx != LAST_LANE) begin
                        lane_idx <= lane_idx + LANE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_lane_sequencer.sv
// Directed bench: sequencer plus a behavioural scalar ALU in a loop.
module tb_simd_lane_sequencer;

    localparam int DS = 8;
    localparam int LN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [31:0]   in_vec_a;
    logic [31:0]   in_vec_b;
    logic [2:0]    alu_op_select;
    logic [DS-1:0] alu_operand1;
    logic [DS-1:0] alu_operand2;
    logic [DS-1:0] alu_result;
    logic          alu_neg_flag;
    logic          alu_zero_flag;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_vec;
    logic [LN-1:0] out_neg_mask;
    logic [LN-1:0] out_zero_mask;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simd_lane_sequencer #(.DATA_SIZE(DS), .LANES(LN)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_vec_a      (in_vec_a),
        .in_vec_b      (in_vec_b),
        .alu_op_select (alu_op_select),
        .alu_operand1  (alu_operand1),
        .alu_operand2  (alu_operand2),
        .alu_result    (alu_result),
        .alu_neg_flag  (alu_neg_flag),
        .alu_zero_flag (alu_zero_flag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vec       (out_vec),
        .out_neg_mask  (out_neg_mask),
        .out_zero_mask (out_zero_mask),
        .busy          (busy)
    );

    // Scalar ALU stand-in: truncating arithmetic, neg = MSB, zero = all-zero.
    always_comb begin
        alu_result = '0;
        case (alu_op_select)
            3'b001:  alu_result = alu_operand1 ^ alu_operand2;
            3'b010:  alu_result = alu_operand1 + alu_operand2;
            3'b011:  alu_result = alu_operand1 - alu_operand2;
            3'b100:  alu_result = alu_operand1 * alu_operand2;
            3'b111:  alu_result = alu_operand1 + 8'd4;
            default: alu_result = '0;
        endcase
        alu_neg_flag  = alu_result[DS-1];
        alu_zero_flag = (alu_result == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_vec,
                          input logic [3:0] exp_neg,
                          input logic [3:0] exp_zero,
                          input bit hold);
        int n;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_op    = op;
        in_vec_a = a;
        in_vec_b = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_alu_op"}, {29'd0, alu_op_select}, {29'd0, op});
        chk({tag, "_opnd1_l0"}, {24'd0, alu_operand1}, {24'd0, a[7:0]});
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 32'd4);
        chk({tag, "_vec"}, out_vec, exp_vec);
        chk({tag, "_neg"}, {28'd0, out_neg_mask}, {28'd0, exp_neg});
        chk({tag, "_zero"}, {28'd0, out_zero_mask}, {28'd0, exp_zero});
        if (!hold) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_retain"}, out_vec, exp_vec);
        end
    endtask

    logic [31:0] snap_vec;
    int          pulse_t[$];
    int          t;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_vec_a  = '0;
        in_vec_b  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_vec", out_vec, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op_select}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add", 3'b010, 32'h04030201, 32'h01010101,
               32'h05040302, 4'b0000, 4'b0000, 1'b0);
        run_op("sub", 3'b011, 32'h00000305, 32'h00000505,
               32'h0000FE00, 4'b0010, 4'b1101, 1'b0);
        run_op("inc", 3'b111, 32'hFE00007F, 32'h00000000,
               32'h02040483, 4'b0001, 4'b0000, 1'b1);

        // Backpressure: a second op offered while DONE is stalled.
        snap_vec = out_vec;
        in_op    = 3'b001;
        in_vec_a = 32'h11223344;
        in_vec_b = 32'h01020304;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_vec", out_vec, snap_vec);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        chk("bp_neg", {28'd0, out_neg_mask}, 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle", {31'd0, out_valid}, 32'd0);
        run_op("xor", 3'b001, 32'h11223344, 32'h01020304,
               32'h10203040, 4'b0000, 4'b0000, 1'b0);

        // Reset after lanes 0 and 1 have been written.
        in_op    = 3'b100;
        in_vec_a = 32'h02030410;
        in_vec_b = 32'h03030310;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_vec_l1", {16'd0, out_vec[15:0]}, 32'h00000C00);
        rst = 1'b1;
        tick();
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_vec", out_vec, 32'd0);
        chk("rst2_masks", {24'd0, out_neg_mask, out_zero_mask}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst2_valid_after", {31'd0, out_valid}, 32'd0);
        run_op("mul", 3'b100, 32'h02030410, 32'h03030310,
               32'h06090C00, 4'b0000, 4'b0001, 1'b0);

        // Back-to-back with both handshakes held high.
        in_op     = 3'b010;
        in_vec_a  = 32'h01010101;
        in_vec_b  = 32'h01010101;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t = 0;
        while (pulse_t.size() < 3 && t < 60) begin
            tick();
            t++;
            if (out_valid) pulse_t.push_back(t);
        end
        in_valid = 1'b0;
        chk("b2b_pulses", pulse_t.size(), 32'd3);
        if (pulse_t.size() == 3) begin
            chk("b2b_gap1", pulse_t[1] - pulse_t[0], 32'd6);
            chk("b2b_gap2", pulse_t[2] - pulse_t[1], 32'd6);
        end
        chk("b2b_vec", out_vec, 32'h02020202);
        for (int i = 0; i < 8; i++) tick();
        chk("b2b_drained", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
